// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit memory port.
//
// Accepts one load or store request at a time from the pipeline, computes the
// effective address (base + imm), classifies the access (illegal funct3,
// misaligned, out-of-range), and drives a single-cycle memory strobe for
// legal accesses. Results are held on the response channel until consumed.
// A memory dump can be requested while idle and no request is pending.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   req_*               - pipeline request channel (valid/ready handshake)
//   resp_*              - response channel (valid/ready handshake),
//                         resp_err: 00 ok, 01 misaligned, 10 fault, 11 illegal
//   dump_req            - request a memory dump
//   mem_*               - memory-side strobe, address, data and control
module lsu_mem_port #(
    parameter bit ALIGN_CHECK = 1'b1,
    parameter bit BOUND_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_imm,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [1:0]  resp_err,
    input  logic        dump_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_length,
    output logic        mem_sign,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic        mem_createdump,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        DUMP   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_data_in;
    logic [1:0]  r_mem_length;
    logic        r_mem_sign;
    logic        r_store;
    logic [31:0] r_resp_data;
    logic [1:0]  r_resp_err;

    logic [31:0] w_addr;
    logic        w_legal;
    logic [1:0]  w_len;
    logic        w_sign;
    logic        w_misal;
    logic        w_fault;
    logic [1:0]  w_err;
    logic        w_accept;

    // Sign- or zero-extend the right-aligned memory read data to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] d,
                                                input logic [1:0]  len,
                                                input logic        sgn);
        logic [31:0] r;
        case (len)
            2'b00:   r = sgn ? {{24{d[7]}}, d[7:0]}   : {24'h000000, d[7:0]};
            2'b01:   r = sgn ? {{16{d[15]}}, d[15:0]} : {16'h0000, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Carry out of the address add is intentionally discarded.
    assign w_addr   = req_base + req_imm;
    assign w_accept = req_valid & req_ready;

    // funct3 decode: access width, signedness and legality.
    always_comb begin
        w_legal = 1'b0;
        w_len   = 2'b00;
        w_sign  = 1'b0;
        case (req_funct3)
            3'b000: begin w_legal = 1'b1;       w_len = 2'b00; w_sign = ~req_store; end
            3'b001: begin w_legal = 1'b1;       w_len = 2'b01; w_sign = ~req_store; end
            3'b010: begin w_legal = 1'b1;       w_len = 2'b10; w_sign = 1'b0;       end
            3'b100: begin w_legal = ~req_store; w_len = 2'b00; w_sign = 1'b0;       end
            3'b101: begin w_legal = ~req_store; w_len = 2'b01; w_sign = 1'b0;       end
            default: begin w_legal = 1'b0;      w_len = 2'b00; w_sign = 1'b0;       end
        endcase
    end

    // Error classification; illegal outranks misaligned, which outranks fault.
    always_comb begin
        w_misal = ALIGN_CHECK && (((w_len == 2'b01) && w_addr[0]) ||
                                  ((w_len == 2'b10) && (w_addr[1:0] != 2'b00)));
        w_fault = BOUND_CHECK && (w_addr[31:16] != 16'h0000);
        if (!w_legal) begin
            w_err = 2'b11;
        end else if (w_misal) begin
            w_err = 2'b01;
        end else if (w_fault) begin
            w_err = 2'b10;
        end else begin
            w_err = 2'b00;
        end
    end

    // Next-state logic; a pending request always wins over a dump request.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next = (w_err == 2'b00) ? ACCESS : RESP;
                end else if (dump_req) begin
                    w_next = DUMP;
                end else begin
                    w_next = IDLE;
                end
            end
            ACCESS:  w_next = RESP;
            RESP:    w_next = resp_ready ? IDLE : RESP;
            DUMP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request capture at acceptance and load data capture at the end of ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr    <= 32'h0000_0000;
            r_mem_data_in <= 32'h0000_0000;
            r_mem_length  <= 2'b00;
            r_mem_sign    <= 1'b0;
            r_store       <= 1'b0;
            r_resp_data   <= 32'h0000_0000;
            r_resp_err    <= 2'b00;
        end else if (w_accept) begin
            r_mem_addr    <= w_addr;
            r_mem_data_in <= req_store ? req_wdata : 32'h0000_0000;
            r_mem_length  <= w_len;
            r_mem_sign    <= w_sign;
            r_store       <= req_store;
            r_resp_data   <= 32'h0000_0000;
            r_resp_err    <= w_err;
        end else if (r_state == ACCESS) begin
            r_resp_data   <= r_store ? 32'h0000_0000
                                     : load_extend(mem_data_out, r_mem_length, r_mem_sign);
        end
    end

    // Strobes decode directly from the state register so reset kills them
    // immediately, preventing a store commit when reset hits mid-ACCESS.
    assign req_ready      = (r_state == IDLE) && !rst;
    assign resp_valid     = (r_state == RESP);
    assign resp_data      = r_resp_data;
    assign resp_err       = r_resp_err;
    assign mem_addr       = r_mem_addr;
    assign mem_data_in    = r_mem_data_in;
    assign mem_length     = r_mem_length;
    assign mem_sign       = r_mem_sign;
    assign mem_enable     = (r_state == ACCESS);
    assign mem_wr         = (r_state == ACCESS) && r_store;
    assign mem_createdump = (r_state == DUMP);

endmodule
